data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 50 +++++
 rtl/data_sram_resp_sram.sv | 52 +++++
 rtl/data_sram_resp.sv | 140 ++++++++++++++
 tb/tb_data_sram_resp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_resp_pkg
//   Shared constants and helpers for the data-side SRAM responder: the default
//   MMIO window base, the register offsets inside that window, the register
//   select enum produced by the offset decoder, and a byte-lane merge helper
//   used by every lane-masked write.
// -----------------------------------------------------------------------------
package data_sram_resp_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

  localparam logic [15:0] OFF_TIMER  = 16'h0000;
  localparam logic [15:0] OFF_LED    = 16'h0004;
  localparam logic [15:0] OFF_SWITCH = 16'h0008;
  localparam logic [15:0] OFF_NUM    = 16'h000C;

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    REG_TIMER,
    REG_LED,
    REG_SWITCH,
    REG_NUM,
    REG_NONE
  } mmio_reg_e;

  // Offsets match exactly; anything else in the window is a hole.
  function automatic mmio_reg_e decode_offset(input logic [15:0] offset);
    case (offset)
      OFF_TIMER:  return REG_TIMER;
      OFF_LED:    return REG_LED;
      OFF_SWITCH: return REG_SWITCH;
      OFF_NUM:    return REG_NUM;
      default:    return REG_NONE;
    endcase
  endfunction

  // Lane i of the result comes from wdata when we[i] is set, else from old.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
    logic [31:0] result;
    result = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we[i]) result[8*i +: 8] = wdata[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/data_sram_resp_sram.sv
// -----------------------------------------------------------------------------
// sram_byte_array
//   Single-port 2^ADDR_W x 32-bit RAM with per-byte write enables and a
//   registered read port. The read register only loads on a read, so it holds
//   its value through writes and idle cycles.
//
//   clk    : clock
//   reset  : async active-high; clears the read register, blocks writes
//   en     : access request
//   we     : byte-lane write enables (zero = read)
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data
// -----------------------------------------------------------------------------
module sram_byte_array
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset branch on purpose; only the read
  // register is cleared. Keeping the array out of reset lets it map onto RAM
  // macros. Writes are still held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (en && !reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && (we == 4'b0000)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//   Data-side SRAM responder. Accesses whose upper address half matches the
//   MMIO window go to four small registers (free-running TIMER, LED, synced
//   SWITCH, NUM); everything else goes to the byte-array RAM. Read data is
//   returned one cycle after the request and held until the next read.
//
//   clk             : clock, all state on the rising edge
//   reset           : async active-high
//   data_sram_en    : access request
//   data_sram_we    : byte-lane write enables (zero = read)
//   data_sram_addr  : byte address
//   data_sram_wdata : write data
//   data_sram_rdata : read data, one-cycle latency, held between reads
//   switch_in       : asynchronous board switches
//   led_out         : LED register
//   num_out         : numeric-display register
// -----------------------------------------------------------------------------
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  logic        is_mmio;
  logic        rd_req;
  logic        wr_req;
  logic        ram_en;
  mmio_reg_e   mmio_sel;
  logic [31:0] ram_rdata;

  logic [31:0] timer_q;
  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;
  logic [31:0] mmio_rdata_q;
  logic        rd_was_mmio_q;

  logic [31:0] timer_inc;
  logic [31:0] led_merged;
  logic [31:0] timer_next;
  logic [15:0] led_next;
  logic [31:0] num_next;
  logic [31:0] mmio_rd_val;

  assign is_mmio  = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign rd_req   = data_sram_en && (data_sram_we == 4'b0000);
  assign wr_req   = data_sram_en && (data_sram_we != 4'b0000);
  assign ram_en   = data_sram_en && !is_mmio;
  assign mmio_sel = decode_offset(data_sram_addr[15:0]);

  assign timer_inc  = timer_q + 32'd1;
  assign led_merged = merge_lanes({16'h0000, led_q}, data_sram_wdata, data_sram_we);

  // Upper address bits above the word index are simply not wired, so the
  // array aliases across the whole non-MMIO space.
  sram_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (data_sram_we),
    .addr  (data_sram_addr[ADDR_W+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    timer_next  = timer_inc;
    led_next    = led_q;
    num_next    = num_q;
    mmio_rd_val = '0;

    // A TIMER write wins over the increment, lane by lane: unwritten lanes
    // still take the incremented value.
    if (wr_req && is_mmio) begin
      case (mmio_sel)
        REG_TIMER: timer_next = merge_lanes(timer_inc, data_sram_wdata, data_sram_we);
        REG_LED:   led_next   = led_merged[15:0];
        REG_NUM:   num_next   = merge_lanes(num_q, data_sram_wdata, data_sram_we);
        default:   ;
      endcase
    end

    case (mmio_sel)
      REG_TIMER:  mmio_rd_val = timer_q;
      REG_LED:    mmio_rd_val = {16'h0000, led_q};
      REG_SWITCH: mmio_rd_val = {24'h000000, sw_sync_q};
      REG_NUM:    mmio_rd_val = num_q;
      default:    mmio_rd_val = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q       <= '0;
      led_q         <= '0;
      num_q         <= '0;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      mmio_rdata_q  <= '0;
      rd_was_mmio_q <= 1'b0;
    end else begin
      timer_q   <= timer_next;
      led_q     <= led_next;
      num_q     <= num_next;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
      if (rd_req) begin
        rd_was_mmio_q <= is_mmio;
        if (is_mmio) mmio_rdata_q <= mmio_rd_val;
      end
    end
  end

  // Both sources are registers that only change on their own reads, and the
  // select only changes on a read, so the output holds between reads.
  assign data_sram_rdata = rd_was_mmio_q ? mmio_rdata_q : ram_rdata;
  assign led_out         = led_q;
  assign num_out         = num_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//   Self-checking bench for data_sram_resp: directed scenarios with fixed
//   expected values, then randomized traffic compared against a transaction
//   level model (associative-array RAM, plain register variables).
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

  localparam int          ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in = 8'h00;
  logic [15:0] led_out;
  logic [31:0] num_out;

  data_sram_resp #(
    .ADDR_W    (ADDR_W),
    .MMIO_BASE (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .num_out         (num_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [int];
  logic [31:0] m_timer;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [7:0]  m_sw1;
  logic [7:0]  m_sw2;
  logic [31:0] m_rdata;
  bit          m_rdata_known;

  task automatic model_reset();
    m_timer = 0; m_led = 0; m_num = 0; m_sw1 = 0; m_sw2 = 0;
    m_rdata = 0; m_rdata_known = 1;
  endtask

  // One clock edge worth of behaviour, computed from pre-edge model state.
  task automatic model_step(input logic en, input logic [3:0] we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] sw);
    bit          mmio;
    int          widx;
    logic [15:0] off;
    logic [31:0] t_next;
    logic [31:0] word;
    mmio   = (addr[31:16] == BASE[31:16]);
    widx   = int'((addr / 4) % (1 << ADDR_W));
    off    = addr[15:0];
    t_next = m_timer + 1;
    if (en && we == 4'h0) begin
      m_rdata_known = 1;
      if (mmio) begin
        if      (off == 16'h0000) m_rdata = m_timer;
        else if (off == 16'h0004) m_rdata = {16'h0, m_led};
        else if (off == 16'h0008) m_rdata = {24'h0, m_sw2};
        else if (off == 16'h000C) m_rdata = m_num;
        else                      m_rdata = 0;
      end else if (m_ram.exists(widx)) begin
        m_rdata = m_ram[widx];
      end else begin
        m_rdata_known = 0;
      end
    end
    if (en && we != 4'h0) begin
      if (mmio) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) begin
            if (off == 16'h0000) t_next[8*i +: 8] = wdata[8*i +: 8];
            if (off == 16'h0004 && i < 2) m_led[8*i +: 8] = wdata[8*i +: 8];
            if (off == 16'h000C) m_num[8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end else begin
        word = m_ram.exists(widx) ? m_ram[widx] : 32'h0;
        for (int i = 0; i < 4; i++) if (we[i]) word[8*i +: 8] = wdata[8*i +: 8];
        m_ram[widx] = word;
      end
    end
    m_timer = t_next;
    m_sw2   = m_sw1;
    m_sw1   = sw;
  endtask

  // Drive one cycle, let the edge happen, then compare all outputs.
  task automatic access(input logic en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    model_step(en, we, addr, wdata, switch_in);
    #1;
    if (m_rdata_known) check({tag, ".rdata"}, data_sram_rdata, m_rdata);
    check({tag, ".led"}, {16'h0, led_out}, {16'h0, m_led});
    check({tag, ".num"}, num_out, m_num);
  endtask

  task automatic idle(input string tag);
    access(1'b0, 4'h0, 32'h0, 32'h0, tag);
  endtask

  logic [31:0] saved_word4;
  logic [31:0] a;
  logic [3:0]  w;
  logic        e;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.rdata", data_sram_rdata, 32'h0);
    check("reset.led", {16'h0, led_out}, 32'h0);
    check("reset.num", num_out, 32'h0);
    #1 reset = 1'b0;

    // First edge after release: TIMER read sees 0.
    access(1'b1, 4'h0, BASE, 32'h0, "first_timer");
    check("first_timer.val", data_sram_rdata, 32'h0);

    // Full write then read back.
    access(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, "w10");
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "r10");
    check("full_write", data_sram_rdata, 32'h1234_5678);

    // Lane-masked write, then byte-offset read of the same word.
    access(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD, "w10m");
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "r10m");
    check("lane_write", data_sram_rdata, 32'h12BB_56DD);
    access(1'b1, 4'h0, 32'h0000_0012, 32'h0, "r12");
    check("byte_offset", data_sram_rdata, 32'h12BB_56DD);

    // Aliasing above the word index.
    access(1'b1, 4'h0, 32'h0000_4010, 32'h0, "r4010");
    check("alias", data_sram_rdata, 32'h12BB_56DD);

    // TIMER write and wrap; rdata held through the write and idle cycles.
    access(1'b1, 4'hF, BASE, 32'hFFFF_FFFE, "wtimer");
    check("hold_on_write", data_sram_rdata, 32'h12BB_56DD);
    idle("idle1");
    check("hold_idle1", data_sram_rdata, 32'h12BB_56DD);
    idle("idle2");
    check("hold_idle2", data_sram_rdata, 32'h12BB_56DD);
    access(1'b1, 4'h0, BASE, 32'h0, "rtimer_a");
    check("timer_wrap0", data_sram_rdata, 32'h0000_0000);
    access(1'b1, 4'h0, BASE, 32'h0, "rtimer_b");
    check("timer_wrap1", data_sram_rdata, 32'h0000_0001);

    // LED, SWITCH, NUM and an unmapped hole.
    access(1'b1, 4'hF, BASE + 32'h4, 32'hDEAD_BEEF, "wled");
    check("led_out", {16'h0, led_out}, 32'h0000_BEEF);
    access(1'b1, 4'h0, BASE + 32'h4, 32'h0, "rled");
    check("led_read", data_sram_rdata, 32'h0000_BEEF);
    switch_in = 8'h5A;
    idle("sw1");
    idle("sw2");
    access(1'b1, 4'h0, BASE + 32'h8, 32'h0, "rsw");
    check("switch_read", data_sram_rdata, 32'h0000_005A);
    access(1'b1, 4'hF, BASE + 32'h8, 32'hFFFF_FFFF, "wsw");
    access(1'b1, 4'h0, BASE + 32'h8, 32'h0, "rsw2");
    check("switch_ro", data_sram_rdata, 32'h0000_005A);
    access(1'b1, 4'h0, BASE + 32'h20, 32'h0, "rhole");
    check("hole_read", data_sram_rdata, 32'h0);
    access(1'b1, 4'hF, BASE + 32'hC, 32'h1122_3344, "wnum");
    access(1'b1, 4'b1010, BASE + 32'hC, 32'hAABB_CCDD, "wnum_m");
    check("num_lanes", num_out, 32'hAA22_CC44);

    // Fill a small set of words, then randomized traffic.
    for (int i = 0; i < 16; i++) access(1'b1, 4'hF, 32'(i * 4), $urandom, "init");
    for (int n = 0; n < 1500; n++) begin
      switch_in = 8'($urandom);
      e = ($urandom_range(0, 99) < 85);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0, 1: begin
          a[13:2] = 12'($urandom_range(0, 15));
          if (a[31:16] == BASE[31:16]) a[31:16] = a[31:16] ^ 16'h0001;
        end
        2: a = BASE + 32'(4 * $urandom_range(0, 3));
        default: a[31:16] = BASE[31:16];
      endcase
      access(e, w, a, $urandom, "rand");
    end

    // Reset asserted mid-cycle with a write pending.
    switch_in = 8'h00;
    access(1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, "pre_w4");
    access(1'b1, 4'hF, BASE + 32'h4, 32'h0000_1234, "pre_led");
    access(1'b1, 4'hF, BASE + 32'hC, 32'h5555_AAAA, "pre_num");
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "pre_r4");
    saved_word4 = m_ram[4];
    data_sram_en    = 1'b1;
    data_sram_we    = 4'hF;
    data_sram_addr  = 32'h0000_0010;
    data_sram_wdata = 32'h0BAD_0BAD;
    reset = 1'b1;
    #1;
    check("rst.rdata", data_sram_rdata, 32'h0);
    check("rst.led", {16'h0, led_out}, 32'h0);
    check("rst.num", num_out, 32'h0);
    repeat (2) @(posedge clk);
    #2;
    data_sram_en = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check("post_rst.rdata", data_sram_rdata, 32'h0);
    access(1'b1, 4'h0, BASE, 32'h0, "post_rst_timer");
    check("post_rst.timer", data_sram_rdata, 32'h0);
    access(1'b1, 4'h0, 32'h0000_0010, 32'h0, "post_rst_r4");
    check("post_rst.word4", data_sram_rdata, saved_word4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
